// File: rtl/engine_host_seq.sv
// Host-side sequencer for the vector compute engine: streams n operand pairs
// into the engine, waits for completion, then reads the n results back out
// onto a valid/ready stream, one result at a time.
module engine_host_seq #(
    parameter int DW      = 32,
    parameter int AW      = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   cfg_n,
    input  logic          start,
    output logic          busy,
    output logic          err_len,
    output logic          err_timeout,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_a,
    input  logic [DW-1:0] s_b,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          eng_we,
    output logic          eng_category,
    output logic [AW-1:0] eng_index,
    output logic [DW-1:0] eng_a_data,
    output logic [DW-1:0] eng_b_data,
    output logic [31:0]   eng_n,
    input  logic [DW-1:0] eng_c_data,
    input  logic          eng_done
);
    localparam logic [31:0] MAX_N = 32'(2 ** AW);
    localparam logic [31:0] TO_M1 = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_READ_A, S_READ_C, S_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] k;
    logic [31:0]   wcnt;
    logic          start_ok;
    logic          is_last;
    logic          timeout_hit;

    // Length check happens on the raw cfg_n; eng_n only holds accepted lengths.
    assign start_ok    = start && (cfg_n != 32'd0) && (cfg_n <= MAX_N);
    assign is_last     = (32'(k) == eng_n - 32'd1);
    assign timeout_hit = (state == S_WAIT) && !eng_done && (wcnt == TO_M1);
    assign busy        = (state != S_IDLE);
    assign m_last      = m_valid && is_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and engine/upstream strobes; engine buses are zero
    // whenever they are not being driven so an idle host is all-quiet.
    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        eng_we       = 1'b0;
        eng_category = 1'b0;
        eng_index    = '0;
        eng_a_data   = '0;
        eng_b_data   = '0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    eng_we     = 1'b1;
                    eng_index  = k;
                    eng_a_data = s_a;
                    eng_b_data = s_b;
                    if (is_last) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done)         state_nxt = S_READ_A;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_READ_A: begin
                eng_category = 1'b1;
                eng_index    = k;
                state_nxt    = S_READ_C;
            end
            S_READ_C: state_nxt = S_OUT;
            S_OUT: begin
                if (m_ready) state_nxt = is_last ? S_IDLE : S_READ_A;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job length, element counter, WAIT watchdog, result register, error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            k           <= '0;
            wcnt        <= '0;
            eng_n       <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_len     <= (state == S_IDLE) && start && !start_ok;
            err_timeout <= timeout_hit;
            case (state)
                S_IDLE: begin
                    k <= '0;
                    if (start_ok) eng_n <= cfg_n;
                end
                S_LOAD: begin
                    wcnt <= '0;
                    if (s_valid && !is_last) k <= k + AW'(1);
                end
                S_WAIT: begin
                    k    <= '0;
                    wcnt <= wcnt + 32'd1;
                end
                S_READ_C: begin
                    m_data  <= eng_c_data;
                    m_valid <= 1'b1;
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (!is_last) k <= k + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
